// File: rtl/parking_pay_ctrl_if.sv
// Purpose : lane-side signal bundle for the parking exit payment controller.
//           Groups ticket reader, bill acceptor, lane sensor and the controller
//           outputs (invoice, barrier, change pulses, amount owed, busy).
// Ports   : master drives ticket/tiempo/billete/sensor and observes outputs;
//           slave (the controller) observes inputs and drives
//           factura/talanquera/vuelto/saldo/busy.
interface parking_pay_ctrl_if #(
    parameter int TIME_W = 2,
    parameter int BILL_W = 2,
    parameter int CW     = 6
);
    logic              ticket;
    logic [TIME_W-1:0] tiempo;
    logic [BILL_W-1:0] billete;
    logic              sensor;
    logic              factura;
    logic              talanquera;
    logic              vuelto;
    logic [CW-1:0]     saldo;
    logic              busy;

    modport master (
        output ticket, tiempo, billete, sensor,
        input  factura, talanquera, vuelto, saldo, busy
    );

    modport slave (
        input  ticket, tiempo, billete, sensor,
        output factura, talanquera, vuelto, saldo, busy
    );
endinterface

// File: rtl/parking_pay_ctrl.sv
// Purpose : parking exit lane controller. Latches a fee from the time code on
//           a ticket edge, credits bill edges until the fee is covered, pays
//           change as pulses, pulses the invoice and holds the barrier open
//           until the vehicle has passed. Abandoned payments are refunded.
// Ports   : clk   - rising-edge clock
//           reset - asynchronous active-low reset
//           lane  - parking_pay_ctrl_if.slave (ticket, tiempo, billete, sensor
//                   in; factura, talanquera, vuelto, saldo, busy out)
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for a ticket edge, barrier closed
// S_COLLECT | accumulating bill credit against the latched price
// S_CHANGE  | paying overpayment back as pulse/gap pairs, then open
// S_OPEN    | invoice pulsed, barrier open, waiting for vehicle or timeout
// S_PASSING | vehicle under barrier, waiting for the lane to clear
// S_REFUND  | returning all credit after payment timeout, then idle
module parking_pay_ctrl #(
    parameter int TIME_W     = 2,
    parameter int BILL_W     = 2,
    parameter int CW         = 6,
    parameter int PRICE_STEP = 2,
    parameter int TIMEOUT    = 200
) (
    input logic                clk,
    input logic                reset,
    parking_pay_ctrl_if.slave  lane
);
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] T_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_CHANGE, S_OPEN, S_PASSING, S_REFUND
    } state_t;

    state_t            r_state;
    logic              r_ticket_q;
    logic [BILL_W-1:0] r_bill_q;
    logic [CW-1:0]     r_price;
    logic [CW-1:0]     r_credit;
    logic [CW-1:0]     r_change;
    logic [TMR_W-1:0]  r_timer;
    logic              r_factura;
    logic              r_talanquera;
    logic              r_vuelto;
    logic [CW-1:0]     r_saldo;
    logic              r_busy;

    logic              w_ticket_ev;
    logic              w_bill_ev;
    logic [CW-1:0]     w_bill_val;
    logic [CW-1:0]     w_price_new;

    assign w_ticket_ev = lane.ticket & ~r_ticket_q;
    assign w_bill_ev   = (lane.billete != '0) && (r_bill_q == '0);
    assign w_bill_val  = CW'(lane.billete);
    assign w_price_new = (CW'(lane.tiempo) + CW'(1)) * CW'(PRICE_STEP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_ticket_q   <= 1'b0;
            r_bill_q     <= '0;
            r_price      <= '0;
            r_credit     <= '0;
            r_change     <= '0;
            r_timer      <= '0;
            r_factura    <= 1'b0;
            r_talanquera <= 1'b0;
            r_vuelto     <= 1'b0;
            r_saldo      <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_ticket_q <= lane.ticket;
            r_bill_q   <= lane.billete;
            r_factura  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_ticket_ev) begin
                        r_price  <= w_price_new;
                        r_credit <= '0;
                        r_timer  <= '0;
                        r_saldo  <= w_price_new;
                        r_busy   <= 1'b1;
                        r_state  <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (r_credit >= r_price) begin
                        r_saldo <= '0;
                        r_timer <= '0;
                        if (r_credit != r_price) begin
                            // first pulse goes out now, so one unit is already paid
                            r_change <= r_credit - r_price - CW'(1);
                            r_vuelto <= 1'b1;
                            r_state  <= S_CHANGE;
                        end else begin
                            r_factura    <= 1'b1;
                            r_talanquera <= 1'b1;
                            r_state      <= S_OPEN;
                        end
                    end else begin
                        // saldo follows the registered credit, one edge behind a bill
                        r_saldo <= r_price - r_credit;
                        if (w_bill_ev) begin
                            r_credit <= r_credit + w_bill_val;
                            r_timer  <= '0;
                        end else if (r_timer == T_LAST) begin
                            r_saldo <= '0;
                            r_timer <= '0;
                            if (r_credit != '0) begin
                                r_change <= r_credit - CW'(1);
                                r_vuelto <= 1'b1;
                                r_state  <= S_REFUND;
                            end else begin
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_timer <= r_timer + TMR_W'(1);
                        end
                    end
                end
                S_CHANGE, S_REFUND: begin
                    if (r_vuelto) begin
                        r_vuelto <= 1'b0;
                    end else if (r_change != '0) begin
                        r_vuelto <= 1'b1;
                        r_change <= r_change - CW'(1);
                    end else if (r_state == S_CHANGE) begin
                        r_factura    <= 1'b1;
                        r_talanquera <= 1'b1;
                        r_timer      <= '0;
                        r_state      <= S_OPEN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_OPEN: begin
                    // a vehicle arriving wins over an expiring timer
                    if (!lane.sensor) begin
                        r_state <= S_PASSING;
                    end else if (r_timer == T_LAST) begin
                        r_talanquera <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                S_PASSING: begin
                    if (lane.sensor) begin
                        r_talanquera <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_talanquera <= 1'b0;
                    r_vuelto     <= 1'b0;
                    r_saldo      <= '0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign lane.factura    = r_factura;
    assign lane.talanquera = r_talanquera;
    assign lane.vuelto     = r_vuelto;
    assign lane.saldo      = r_saldo;
    assign lane.busy       = r_busy;
endmodule

// File: tb/tb_parking_pay_ctrl.sv
// Purpose : self-checking bench for parking_pay_ctrl. A per-cycle vector table
//           covers exact payment, overpayment and ticket/bill collision; short
//           hand-written sequences cover held bills, abandonment, barrier
//           timeout, a blocked lane and reset during change.
module tb_parking_pay_ctrl;
    localparam int TIME_W     = 2;
    localparam int BILL_W     = 2;
    localparam int CW         = 6;
    localparam int PRICE_STEP = 2;
    localparam int TIMEOUT    = 320;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    parking_pay_ctrl_if #(.TIME_W(TIME_W), .BILL_W(BILL_W), .CW(CW)) lane ();

    parking_pay_ctrl #(
        .TIME_W(TIME_W), .BILL_W(BILL_W), .CW(CW),
        .PRICE_STEP(PRICE_STEP), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .lane (lane)
    );

    typedef struct {
        int tk; int tm; int bl; int sn;
        int fac; int tal; int vu; int busy; int saldo;
    } vec_t;

    vec_t tbl [28];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int tk, input int tm, input int bl, input int sn);
        lane.ticket  = 1'(tk);
        lane.tiempo  = TIME_W'(tm);
        lane.billete = BILL_W'(bl);
        lane.sensor  = 1'(sn);
    endtask

    task automatic check_all(input string tag, input int fac, input int tal,
                             input int vu, input int busy, input int saldo);
        check({tag, " factura"},    int'(lane.factura),    fac);
        check({tag, " talanquera"}, int'(lane.talanquera), tal);
        check({tag, " vuelto"},     int'(lane.vuelto),     vu);
        check({tag, " busy"},       int'(lane.busy),       busy);
        check({tag, " saldo"},      int'(lane.saldo),      saldo);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 1);
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        int first_k, end_k, n_vu, n_fac, n_low;

        //          tk tm bl sn  fac tal vu busy saldo
        tbl[0]  = '{1, 1, 0, 1,  0, 0, 0, 1, 4};
        tbl[1]  = '{1, 1, 2, 1,  0, 0, 0, 1, 4};
        tbl[2]  = '{1, 1, 0, 1,  0, 0, 0, 1, 2};
        tbl[3]  = '{1, 1, 2, 1,  0, 0, 0, 1, 2};
        tbl[4]  = '{1, 1, 0, 1,  1, 1, 0, 1, 0};
        tbl[5]  = '{1, 1, 0, 1,  0, 1, 0, 1, 0};
        tbl[6]  = '{1, 1, 0, 0,  0, 1, 0, 1, 0};
        tbl[7]  = '{1, 1, 0, 0,  0, 1, 0, 1, 0};
        tbl[8]  = '{1, 1, 0, 1,  0, 0, 0, 0, 0};
        tbl[9]  = '{0, 0, 0, 1,  0, 0, 0, 0, 0};
        tbl[10] = '{1, 0, 0, 1,  0, 0, 0, 1, 2};
        tbl[11] = '{1, 0, 3, 1,  0, 0, 0, 1, 2};
        tbl[12] = '{1, 0, 0, 1,  0, 0, 1, 1, 0};
        tbl[13] = '{1, 0, 0, 1,  0, 0, 0, 1, 0};
        tbl[14] = '{1, 0, 0, 1,  1, 1, 0, 1, 0};
        tbl[15] = '{1, 0, 0, 0,  0, 1, 0, 1, 0};
        tbl[16] = '{1, 0, 0, 1,  0, 0, 0, 0, 0};
        tbl[17] = '{0, 0, 0, 1,  0, 0, 0, 0, 0};
        tbl[18] = '{1, 1, 2, 1,  0, 0, 0, 1, 4};
        tbl[19] = '{1, 1, 2, 1,  0, 0, 0, 1, 4};
        tbl[20] = '{1, 1, 0, 1,  0, 0, 0, 1, 4};
        tbl[21] = '{1, 1, 3, 1,  0, 0, 0, 1, 4};
        tbl[22] = '{1, 1, 0, 1,  0, 0, 0, 1, 1};
        tbl[23] = '{1, 1, 1, 1,  0, 0, 0, 1, 1};
        tbl[24] = '{1, 1, 0, 1,  1, 1, 0, 1, 0};
        tbl[25] = '{1, 1, 0, 0,  0, 1, 0, 1, 0};
        tbl[26] = '{1, 1, 0, 1,  0, 0, 0, 0, 0};
        tbl[27] = '{0, 0, 0, 1,  0, 0, 0, 0, 0};

        drive(0, 0, 0, 1);
        reset = 1'b0;
        #12;
        check_all("reset", 0, 0, 0, 0, 0);
        do_reset();
        check_all("post_reset", 0, 0, 0, 0, 0);

        for (int i = 0; i < 28; i++) begin
            drive(tbl[i].tk, tbl[i].tm, tbl[i].bl, tbl[i].sn);
            tick();
            check_all($sformatf("row%0d", i), tbl[i].fac, tbl[i].tal,
                      tbl[i].vu, tbl[i].busy, tbl[i].saldo);
        end

        // held bill: credited once, no timeout within 300 cycles
        do_reset();
        drive(1, 1, 0, 1);
        tick();
        lane.billete = 2'd2;
        n_vu = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (lane.vuelto) n_vu++;
        end
        check("held saldo", int'(lane.saldo), 2);
        check("held busy", int'(lane.busy), 1);
        check("held vuelto", n_vu, 0);
        lane.billete = 2'd0;
        tick();
        lane.billete = 2'd2;
        tick();
        lane.billete = 2'd0;
        tick();
        check("held open factura", int'(lane.factura), 1);
        check("held open vuelto", int'(lane.vuelto), 0);

        // abandonment with one unit of credit
        do_reset();
        drive(1, 2, 0, 1);
        tick();
        check("abandon saldo", int'(lane.saldo), 6);
        lane.billete = 2'd1;
        tick();
        lane.billete = 2'd0;
        tick();
        check("abandon saldo after bill", int'(lane.saldo), 5);
        first_k = -1; end_k = -1; n_vu = 0; n_fac = 0;
        for (int k = 2; k <= TIMEOUT + 10; k++) begin
            tick();
            if (lane.vuelto) begin
                n_vu++;
                if (first_k < 0) first_k = k;
            end
            if (lane.factura) n_fac++;
            if (!lane.busy && end_k < 0) end_k = k;
        end
        check("refund first pulse cycle", first_k, TIMEOUT);
        check("refund pulses", n_vu, 1);
        check("refund factura", n_fac, 0);
        check("refund idle cycle", end_k, TIMEOUT + 2);

        // abandonment with no credit
        do_reset();
        drive(1, 2, 0, 1);
        tick();
        end_k = -1; n_vu = 0;
        for (int k = 1; k <= TIMEOUT + 10; k++) begin
            tick();
            if (lane.vuelto) n_vu++;
            if (!lane.busy && end_k < 0) end_k = k;
        end
        check("noshow idle cycle", end_k, TIMEOUT);
        check("noshow pulses", n_vu, 0);

        // barrier timeout with the lane kept clear
        do_reset();
        drive(1, 0, 0, 1);
        tick();
        lane.billete = 2'd2;
        tick();
        lane.billete = 2'd0;
        tick();
        check("btmo open factura", int'(lane.factura), 1);
        check("btmo open barrier", int'(lane.talanquera), 1);
        end_k = -1;
        for (int k = 1; k <= TIMEOUT + 10; k++) begin
            tick();
            if (!lane.talanquera && end_k < 0) end_k = k;
        end
        check("btmo close cycle", end_k, TIMEOUT);
        check("btmo busy", int'(lane.busy), 0);

        // vehicle parked under the barrier: never closes
        lane.ticket = 1'b0;
        tick();
        lane.ticket = 1'b1;
        tick();
        lane.billete = 2'd2;
        tick();
        lane.billete = 2'd0;
        tick();
        lane.sensor = 1'b0;
        n_low = 0;
        for (int k = 0; k < 2 * TIMEOUT; k++) begin
            tick();
            if (!lane.talanquera) n_low++;
        end
        check("blocked barrier low cycles", n_low, 0);
        check("blocked busy", int'(lane.busy), 1);
        lane.sensor = 1'b1;
        tick();
        check("blocked cleared barrier", int'(lane.talanquera), 0);

        // reset in the gap between change pulses
        do_reset();
        drive(1, 0, 0, 1);
        tick();
        lane.billete = 2'd3;
        tick();
        lane.billete = 2'd0;
        tick();
        check("midchg pulse", int'(lane.vuelto), 1);
        tick();
        check("midchg gap busy", int'(lane.busy), 1);
        #2;
        reset = 1'b0;
        #1;
        check_all("midchg async", 0, 0, 0, 0, 0);
        lane.ticket = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_all("midchg released", 0, 0, 0, 0, 0);
        drive(1, 3, 0, 1);
        tick();
        check("midchg new ticket busy", int'(lane.busy), 1);
        check("midchg new ticket saldo", int'(lane.saldo), 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/parking_pay_ctrl.md
# parking_pay_ctrl

Parametrised parking-exit payment controller. It accepts a ticket, computes the fee from the parked-time code, and accumulates bill credit until the fee is covered. It then dispenses change as counted pulses, issues an invoice pulse and opens the barrier until the vehicle has cleared the lane sensor. It is the top-level lane FSM beside the bill acceptor and barrier driver. Unlike the previous generation, it adds configurable tariff and widths, change dispensing, refund on abandonment and barrier timeout.

## Interface
Parameters:
- TIME_W, 2: width of `tiempo` (parked-time code).
- BILL_W, 2: width of `billete`; code value = bill value in units, 0 = no bill.
- CW, 6: credit/price width. Legal only if 2^TIME_W*PRICE_STEP + 2^BILL_W-1 < 2^CW.
- PRICE_STEP, 2: units charged per time step.
- TIMEOUT, 200: idle-payment and barrier-wait limit in cycles (≥2).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- ticket  in  1  ticket present; the rising edge starts a transaction.
- tiempo  in  TIME_W  time code, sampled on the ticket rising edge.
- billete  in  BILL_W  bill acceptor code; held non-zero while a bill is present.
- sensor  in  1  lane sensor: 1 = clear, 0 = vehicle under barrier.
- factura  out  1  one-cycle invoice pulse when payment completes.
- talanquera  out  1  barrier open (level).
- vuelto  out  1  change pulse; one pulse = one unit returned.
- saldo  out  CW  amount still owed (0 outside COLLECT).
- busy  out  1  high in every state except IDLE.

## Operation
- Edge detectors: `ticket` and `billete` are registered once per cycle. A ticket event is ticket=1 with the previous sample 0. A bill event is billete≠0 with the previous sample 0. A bill held for many cycles counts once.
- States: IDLE, COLLECT, CHANGE, OPEN, PASSING, REFUND.
- IDLE: on a ticket event, latch price = (tiempo+1)*PRICE_STEP, clear credit and timer, go to COLLECT.
- COLLECT:
  - saldo = price − credit.
  - A bill event adds its value to credit and clears the timer.
  - If credit ≥ price, set change = credit − price. Go to CHANGE if change > 0, otherwise go to OPEN.
  - If the timer reaches TIMEOUT with no event: go to REFUND with change = credit if credit > 0, else go to IDLE.
  - Ticket events are ignored here.
- CHANGE: vuelto pulses high for 1 cycle, then stays low for 1 cycle, per unit; change decrements on each pulse. At change = 0, go to OPEN.
- REFUND: same pulse pattern as CHANGE, returning the full credit. At 0, go to IDLE. No factura is issued.
- OPEN:
  - factura is pulsed in the first cycle only; talanquera = 1.
  - sensor = 0 goes to PASSING.
  - If the timer reaches TIMEOUT first, go to IDLE and close the barrier.
- PASSING: talanquera = 1. sensor = 1 goes to IDLE. There is no timeout, so the barrier never closes on a vehicle.
- Bill events outside COLLECT are ignored (not credited).
- Arithmetic is unsigned CW-bit. The legality rule on CW guarantees there is no overflow, so no saturation is needed.

## Timing
- Reset (asynchronous, when reset = 0) forces IDLE, credit = 0, timer = 0, and edge registers = 0. All outputs read 0: factura, talanquera, vuelto, saldo and busy. Any pending change is lost.
- All outputs are registered.
- A ticket event in input cycle N is seen as state COLLECT and a valid saldo from the edge after N+1. The first sample after reset counts as previous = 0.
- A bill event updates saldo 2 edges after billete is applied.
- Credit reaching the price gives OPEN 1 cycle later, or the first vuelto pulse 1 cycle later.
- N change units occupy 2N cycles. factura goes high in the cycle after the last low gap.
- Timer increments once per cycle in COLLECT/OPEN and compares with TIMEOUT − 1, so the transition occurs exactly TIMEOUT cycles after the last event.
- A ticket event and a bill event in the same IDLE cycle: the ticket is accepted and the bill is ignored.

## Test plan
- Exact payment: PRICE_STEP=2, tiempo=1 (price 4); bills 2, gap, 2 → saldo 4→2→0; factura 1 pulse; zero vuelto pulses; talanquera=1 until sensor 1→0→1, then 0.
- Overpayment: tiempo=0 (price 2); bill 3 → 1 vuelto pulse, then factura, then barrier open.
- Held bill: billete=2 held 300 cycles with price 4 → credited once; saldo stays 2.
- Abandonment: price 6, one bill of 1, then no bills for TIMEOUT cycles → REFUND with exactly 1 vuelto pulse, no factura, returns to IDLE. Repeat with no bills at all → IDLE with no pulses.
- Barrier timeout: pay exactly, keep sensor=1 for TIMEOUT cycles → talanquera falls and the block returns to IDLE. With sensor=0 held forever, talanquera stays 1.
- Reset mid-CHANGE (price 2, bill 3 with TIME_W=2 max change): drive reset=0 between pulses → all outputs are 0 at once, and a fresh ticket event is accepted after release.
